// File: rtl/csh_dir_ram_if.sv
// ---------------------------------------------------------------------------
// csh_dir_ram_if -- lookup / write / invalidate-sweep bus of the cache
// directory RAM.
//
// master : requester side (drives lookups, writes, sweep start)
// slave  : directory side (csh_dir_ram)
//
// Signals
//   lk_req_h/lk_idx_h/lk_tag_h   lookup request, set index, compare tag
//   lk_rdy_h                     lookup accepted this cycle
//   lk_vld_h                     lookup result valid (one cycle after accept)
//   lk_hit_h/lk_multi_h          per-way hit vector / more than one way hit
//   lk_dir_h                     stored tags of the looked-up set, way 0 in LSBs
//   lk_par_err_h                 per-way stored-parity mismatch
//   wr_req_h/wr_way_h/wr_idx_h/wr_tag_h/wr_valid_h  directory write
//   wr_bad_par_l                 low forces bad parity on write (diagnostic)
//   clr_start_h                  start invalidate sweep
//   clr_busy_h/clr_done_h        sweep in progress / completion pulse
// ---------------------------------------------------------------------------
interface csh_dir_ram_if #(
    parameter int WAYS  = 4,
    parameter int TAG_W = 13,
    parameter int IDX_W = 7
);
    logic                  lk_req_h;
    logic [IDX_W-1:0]      lk_idx_h;
    logic [TAG_W-1:0]      lk_tag_h;
    logic                  lk_rdy_h;
    logic                  lk_vld_h;
    logic [WAYS-1:0]       lk_hit_h;
    logic                  lk_multi_h;
    logic [WAYS*TAG_W-1:0] lk_dir_h;
    logic [WAYS-1:0]       lk_par_err_h;

    logic                  wr_req_h;
    logic [WAYS-1:0]       wr_way_h;
    logic [IDX_W-1:0]      wr_idx_h;
    logic [TAG_W-1:0]      wr_tag_h;
    logic                  wr_valid_h;
    logic                  wr_bad_par_l;

    logic                  clr_start_h;
    logic                  clr_busy_h;
    logic                  clr_done_h;

    modport master (
        output lk_req_h, lk_idx_h, lk_tag_h,
        output wr_req_h, wr_way_h, wr_idx_h, wr_tag_h, wr_valid_h, wr_bad_par_l,
        output clr_start_h,
        input  lk_rdy_h, lk_vld_h, lk_hit_h, lk_multi_h, lk_dir_h, lk_par_err_h,
        input  clr_busy_h, clr_done_h
    );

    modport slave (
        input  lk_req_h, lk_idx_h, lk_tag_h,
        input  wr_req_h, wr_way_h, wr_idx_h, wr_tag_h, wr_valid_h, wr_bad_par_l,
        input  clr_start_h,
        output lk_rdy_h, lk_vld_h, lk_hit_h, lk_multi_h, lk_dir_h, lk_par_err_h,
        output clr_busy_h, clr_done_h
    );
endinterface

// File: rtl/csh_dir_ram.sv
// ---------------------------------------------------------------------------
// csh_dir_ram -- set-associative cache tag directory.
//
// Storage is WAYS x 2^IDX_W entries of {valid, tag[, parity]}. A lookup reads
// the indexed set, compares every way against lk_tag_h and returns registered
// results one cycle later, held until the next accepted lookup. A write
// updates every way selected in wr_way_h. An invalidate sweep walks all sets
// clearing valid bits, one set per cycle; lookups and writes are refused while
// it runs.
//
// Ports
//   clk      sole clock, rising edge
//   reset_l  asynchronous active-low reset (valid bits, sweep FSM, result regs)
//   bus      csh_dir_ram_if.slave (lookup, write and sweep signals)
//
// Parameters WAYS / TAG_W / IDX_W must match those of the connected interface.
//
// Build option
//   CSH_DIR_PAR_EN  when defined, an odd-parity bit is stored per entry and
//                   lk_par_err_h flags every valid way whose stored parity
//                   mismatches its tag. When undefined there is no parity
//                   storage, wr_bad_par_l is ignored and lk_par_err_h is 0.
// ---------------------------------------------------------------------------
module csh_dir_ram #(
    parameter int WAYS  = 4,
    parameter int TAG_W = 13,
    parameter int IDX_W = 7
) (
    input  logic          clk,
    input  logic          reset_l,
    csh_dir_ram_if.slave  bus
);

    localparam int SETS = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    sweep_state_e     state_q;
    sweep_state_e     state_d;
    logic [IDX_W-1:0] sweep_cnt_q;
    logic             busy;
    logic             done;
    logic             lk_acc;
    logic             wr_acc;

    // -----------------------------------------------------------------------
    // Invalidate sweep FSM
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process order.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first; a path that
    // leaves it unassigned would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.clr_start_h) state_d = SWEEP;
            SWEEP:   if (sweep_cnt_q == {IDX_W{1'b1}}) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SWEEP:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Counter runs only in SWEEP and wraps back to 0 on the last set.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sweep_cnt_q <= '0;
        end else if (state_q == SWEEP) begin
            sweep_cnt_q <= sweep_cnt_q + 1'b1;
        end
    end

    assign bus.clr_busy_h = busy;
    assign bus.clr_done_h = done;
    assign bus.lk_rdy_h   = ~busy;

    assign lk_acc = bus.lk_req_h & ~busy;
    assign wr_acc = bus.wr_req_h & ~busy;

    // -----------------------------------------------------------------------
    // Directory storage
    // -----------------------------------------------------------------------
    logic [WAYS-1:0]             valid_q  [SETS];
    logic [WAYS-1:0][TAG_W-1:0]  tag_mem  [SETS];

    // Sweep and write never coincide: writes are refused while busy.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (busy) begin
            valid_q[sweep_cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int w = 0; w < WAYS; w++) begin
                if (bus.wr_way_h[w]) valid_q[bus.wr_idx_h][w] <= bus.wr_valid_h;
            end
        end
    end

    // NOTE: tag (and parity) arrays carry no reset; the valid bits alone decide
    // whether an entry means anything, so the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int w = 0; w < WAYS; w++) begin
                if (bus.wr_way_h[w]) tag_mem[bus.wr_idx_h][w] <= bus.wr_tag_h;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lookup read and compare (reads pre-write contents on a same-index write)
    // -----------------------------------------------------------------------
    logic [WAYS-1:0]            rd_valid;
    logic [WAYS-1:0][TAG_W-1:0] rd_tags;
    logic [WAYS-1:0]            rd_hit;
    logic                       rd_multi;
    logic [WAYS-1:0]            rd_par_err;

    assign rd_valid = valid_q[bus.lk_idx_h];
    assign rd_tags  = tag_mem[bus.lk_idx_h];

    always_comb begin
        rd_hit = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_hit[w] = rd_valid[w] && (rd_tags[w] == bus.lk_tag_h);
        end
    end

    // Clearing the lowest set bit leaves something iff two or more were set.
    assign rd_multi = |(rd_hit & (rd_hit - WAYS'(1)));

`ifdef CSH_DIR_PAR_EN
    logic [WAYS-1:0] par_mem [SETS];
    logic            wr_par;

    // Odd parity: tag plus parity bit holds an odd number of ones.
    assign wr_par = ~(^bus.wr_tag_h) ^ ~bus.wr_bad_par_l;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int w = 0; w < WAYS; w++) begin
                if (bus.wr_way_h[w]) par_mem[bus.wr_idx_h][w] <= wr_par;
            end
        end
    end

    always_comb begin
        rd_par_err = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_par_err[w] = rd_valid[w] &&
                            (par_mem[bus.lk_idx_h][w] != ~(^rd_tags[w]));
        end
    end
`else
    logic unused_bad_par;
    assign unused_bad_par = bus.wr_bad_par_l;
    assign rd_par_err     = '0;
`endif

    // -----------------------------------------------------------------------
    // Registered lookup results, held until the next accepted lookup
    // -----------------------------------------------------------------------
    logic                  lk_vld_q;
    logic [WAYS-1:0]       lk_hit_q;
    logic                  lk_multi_q;
    logic [WAYS*TAG_W-1:0] lk_dir_q;
    logic [WAYS-1:0]       lk_par_err_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            lk_vld_q     <= 1'b0;
            lk_hit_q     <= '0;
            lk_multi_q   <= 1'b0;
            lk_dir_q     <= '0;
            lk_par_err_q <= '0;
        end else begin
            lk_vld_q <= lk_acc;
            if (lk_acc) begin
                lk_hit_q     <= rd_hit;
                lk_multi_q   <= rd_multi;
                lk_dir_q     <= rd_tags;
                lk_par_err_q <= rd_par_err;
            end
        end
    end

    assign bus.lk_vld_h     = lk_vld_q;
    assign bus.lk_hit_h     = lk_hit_q;
    assign bus.lk_multi_h   = lk_multi_q;
    assign bus.lk_dir_h     = lk_dir_q;
    assign bus.lk_par_err_h = lk_par_err_q;

endmodule

// File: doc/csh_dir_ram.md
CSH_DIR_RAM -- requirements
Module: csh_dir_ram

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of cache ways (1..8).
REQ-002 SHALL have parameter TAG_W, default 13, stored tag width (PMA 14-26).
REQ-003 SHALL have parameter IDX_W, default 7, set index width (address 27-33, 128 sets).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_l  in  1  asynchronous active-low reset.
REQ-006 SHALL have port lk_req_h  in  1  lookup request.
REQ-007 SHALL have port lk_idx_h  in  IDX_W  lookup set index.
REQ-008 SHALL have port lk_tag_h  in  TAG_W  lookup compare tag.
REQ-009 SHALL have port lk_rdy_h  out  1  lookup accepted this cycle.
REQ-010 SHALL have port lk_vld_h  out  1  lookup result valid.
REQ-011 SHALL have port lk_hit_h  out  WAYS  per-way hit vector.
REQ-012 SHALL have port lk_multi_h  out  1  more than one way hit.
REQ-013 SHALL have port lk_dir_h  out  WAYS*TAG_W  stored tags of the indexed set, way 0 in LSBs.
REQ-014 SHALL have port lk_par_err_h  out  WAYS  per-way stored-parity mismatch.
REQ-015 SHALL have port wr_req_h  in  1  directory write request.
REQ-016 SHALL have port wr_way_h  in  WAYS  way write-enable mask (any number of bits).
REQ-017 SHALL have port wr_idx_h / wr_tag_h  in  IDX_W / TAG_W  write index and tag.
REQ-018 SHALL have port wr_valid_h  in  1  valid bit value written.
REQ-019 SHALL have port wr_bad_par_l  in  1  low forces inverted (bad) parity on write, diagnostic.
REQ-020 SHALL have port clr_start_h  in  1  start invalidate sweep.
REQ-021 SHALL have port clr_busy_h / clr_done_h  out  1 / 1  sweep in progress / one-cycle completion pulse.

Function
REQ-022 Storage SHALL be WAYS x 2^IDX_W entries of {valid, tag, parity}.
REQ-023 lk_rdy_h SHALL equal not clr_busy_h; lookups with lk_rdy_h low SHALL be dropped.
REQ-024 Accepted lookup SHALL produce lk_vld_h high exactly one cycle later, with lk_hit_h, lk_multi_h, lk_dir_h, lk_par_err_h registered and held until the next accepted lookup.
REQ-025 lk_hit_h[w] SHALL be high iff entry w valid and stored tag equals lk_tag_h.
REQ-026 lk_multi_h SHALL be high iff lk_hit_h has two or more bits set.
REQ-027 Accepted write SHALL update every way selected in wr_way_h at wr_idx_h at the clock edge; wr_way_h all-zero SHALL be a no-op.
REQ-028 Stored parity SHALL be odd parity over tag, inverted when wr_bad_par_l low.
REQ-029 Lookup and write to the same index in one cycle SHALL return pre-write contents.
REQ-030 Writes while clr_busy_h high SHALL be ignored.
REQ-031 Sweep FSM states IDLE, SWEEP, DONE: IDLE->SWEEP on clr_start_h; SWEEP clears valid of all ways at counter index, counter increments 0..2^IDX_W-1; SWEEP->DONE after last index; DONE->IDLE after one cycle.
REQ-032 Sweep SHALL take exactly 2^IDX_W cycles in SWEEP; clr_done_h high only in DONE.
REQ-033 clr_start_h while not IDLE SHALL be ignored.
REQ-034 Sweep counter SHALL wrap to 0 on completion, no overflow state.

Reset
REQ-035 reset_l low SHALL asynchronously clear all valid bits, FSM to IDLE, counter 0.
REQ-036 During reset outputs SHALL be: lk_vld_h 0, lk_hit_h 0, lk_multi_h 0, lk_dir_h 0, lk_par_err_h 0, clr_busy_h 0, clr_done_h 0, lk_rdy_h 1.
REQ-037 Reset mid-sweep SHALL abort the sweep; no clr_done_h pulse.
REQ-038 Tag and parity storage SHALL NOT be reset.

Configuration
REQ-039 Macro CSH_DIR_PAR_EN defined: parity stored per entry and lk_par_err_h[w] set on mismatch for every valid way w, independent of hit.
REQ-040 CSH_DIR_PAR_EN undefined: no parity storage, wr_bad_par_l ignored, lk_par_err_h constant 0.

Verification
REQ-041 Reset, write way 2 idx 5 tag 0x1A3 valid, lookup idx 5 tag 0x1A3 -> next cycle lk_hit_h=0100, lk_multi_h=0.
REQ-042 Write ways 0 and 3 idx 0x7F tag 0x0FF, lookup same -> lk_hit_h=1001, lk_multi_h=1.
REQ-043 Same-cycle write and lookup idx 9 (previously invalid) -> lk_hit_h=0; repeat lookup -> hit.
REQ-044 clr_start_h after filling all sets -> clr_busy_h 128 cycles, clr_done_h one cycle, every lookup then misses; lk_rdy_h low throughout.
REQ-045 With CSH_DIR_PAR_EN, write way 1 with wr_bad_par_l=0, lookup -> lk_par_err_h=0010; without macro -> 0000.
REQ-046 Assert reset_l low at sweep index 40 -> busy drops immediately, no done pulse, all lookups miss.
